// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one pipelined main-memory port between the I-cache fill,
//            the D-cache fill and D-cache write-through stores. Sequences
//            block fills (one address per cycle, in-order returns) and steers
//            returned words to the owning cache.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  localparam int IDX_W          = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_miss_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_miss_addr,
  input  logic              dcache_wr,
  input  logic [ADDR_W-1:0] dcache_wr_addr,
  input  logic [DATA_W-1:0] dcache_wr_data,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              icache_fill_we,
  output logic              dcache_fill_we,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic              icache_fill_done,
  output logic              dcache_fill_done,
  output logic              dcache_wr_ack,
  output logic              icache_busy,
  output logic              dcache_busy
);

  localparam int               c_BLK_W = ADDR_W - IDX_W - 1;
  localparam logic [IDX_W:0]   c_WPB   = (IDX_W+1)'(WORDS_PER_BLOCK);
  localparam logic [IDX_W-1:0] c_LAST  = '1;
  localparam logic             c_OWN_I = 1'b0;
  localparam logic             c_OWN_D = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FILL  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_owner;
  logic [c_BLK_W-1:0]  r_block;
  logic [IDX_W:0]      r_iss;
  logic [IDX_W-1:0]    r_rcv;
  logic                r_mem_en;
  logic                r_mem_wr;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_ifill_done;
  logic                r_dfill_done;
  logic                r_wr_ack;

  logic                w_fill_acc;

  // Byte-within-word and word-within-block bits of the miss addresses are
  // regenerated by the issue counter, so they are intentionally dropped.
  wire w_unused = ^{icache_miss_addr[IDX_W:0], dcache_miss_addr[IDX_W:0]};

  // Arbitration, fill sequencing and registered memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= c_OWN_I;
      r_block      <= '0;
      r_iss        <= '0;
      r_rcv        <= '0;
      r_mem_en     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_ifill_done <= 1'b0;
      r_dfill_done <= 1'b0;
      r_wr_ack     <= 1'b0;
    end else begin
      r_ifill_done <= 1'b0;
      r_dfill_done <= 1'b0;
      r_wr_ack     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Word 0 of a fill is issued in the first FILL cycle, so it is
          // launched here together with the state change.
          if (dcache_miss) begin
            r_owner    <= c_OWN_D;
            r_block    <= dcache_miss_addr[ADDR_W-1:IDX_W+1];
            r_mem_en   <= 1'b1;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= {dcache_miss_addr[ADDR_W-1:IDX_W+1], {IDX_W{1'b0}}, 1'b0};
            r_iss      <= (IDX_W+1)'(1);
            r_state    <= S_FILL;
          end else if (dcache_wr) begin
            r_owner     <= c_OWN_D;
            r_mem_en    <= 1'b1;
            r_mem_wr    <= 1'b1;
            r_mem_addr  <= dcache_wr_addr;
            r_mem_wdata <= dcache_wr_data;
            r_wr_ack    <= 1'b1;
            r_state     <= S_WRITE;
          end else if (icache_miss) begin
            r_owner    <= c_OWN_I;
            r_block    <= icache_miss_addr[ADDR_W-1:IDX_W+1];
            r_mem_en   <= 1'b1;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= {icache_miss_addr[ADDR_W-1:IDX_W+1], {IDX_W{1'b0}}, 1'b0};
            r_iss      <= (IDX_W+1)'(1);
            r_state    <= S_FILL;
          end
        end
        S_WRITE: begin
          r_mem_en    <= 1'b0;
          r_mem_wr    <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
          r_state     <= S_IDLE;
        end
        S_FILL: begin
          if (r_iss < c_WPB) begin
            r_mem_en   <= 1'b1;
            r_mem_addr <= {r_block, r_iss[IDX_W-1:0], 1'b0};
            r_iss      <= r_iss + 1'b1;
          end else begin
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
          end
          if (mem_rvalid) begin
            r_rcv <= r_rcv + 1'b1;
            if (r_rcv == c_LAST) begin
              r_state      <= S_DONE;
              r_dfill_done <= (r_owner == c_OWN_D);
              r_ifill_done <= (r_owner == c_OWN_I);
            end
          end
        end
        S_DONE: begin
          r_iss   <= '0;
          r_rcv   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Returned words are written straight through to the owning cache.
  assign w_fill_acc     = (r_state == S_FILL) & mem_rvalid;
  assign icache_fill_we = w_fill_acc & (r_owner == c_OWN_I);
  assign dcache_fill_we = w_fill_acc & (r_owner == c_OWN_D);
  assign fill_idx       = r_rcv;
  assign fill_data      = mem_rdata;

  assign mem_enable       = r_mem_en;
  assign mem_wr           = r_mem_wr;
  assign mem_addr         = r_mem_addr;
  assign mem_wdata        = r_mem_wdata;
  assign icache_fill_done = r_ifill_done;
  assign dcache_fill_done = r_dfill_done;
  assign dcache_wr_ack    = r_wr_ack;

  // Busy flags see raw requests so the pipeline stalls in the request cycle.
  assign icache_busy = icache_miss | ((r_state != S_IDLE) & (r_owner == c_OWN_I));
  assign dcache_busy = dcache_miss | dcache_wr |
                       ((r_state != S_IDLE) & (r_owner == c_OWN_D));

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with a fixed-latency
//            pipelined memory model and queue-based scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icache_miss = 1'b0;
  logic [15:0] icache_miss_addr = '0;
  logic        dcache_miss = 1'b0;
  logic [15:0] dcache_miss_addr = '0;
  logic        dcache_wr = 1'b0;
  logic [15:0] dcache_wr_addr = '0;
  logic [15:0] dcache_wr_data = '0;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        icache_fill_we, dcache_fill_we;
  logic [2:0]  fill_idx;
  logic [15:0] fill_data;
  logic        icache_fill_done, dcache_fill_done, dcache_wr_ack;
  logic        icache_busy, dcache_busy;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
    .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
    .dcache_wr(dcache_wr), .dcache_wr_addr(dcache_wr_addr),
    .dcache_wr_data(dcache_wr_data),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .icache_fill_we(icache_fill_we), .dcache_fill_we(dcache_fill_we),
    .fill_idx(fill_idx), .fill_data(fill_data),
    .icache_fill_done(icache_fill_done), .dcache_fill_done(dcache_fill_done),
    .dcache_wr_ack(dcache_wr_ack),
    .icache_busy(icache_busy), .dcache_busy(dcache_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { int due; logic [15:0] addr; } rd_t;
  typedef struct packed { logic d; logic [2:0] idx; logic [15:0] data; } fill_t;
  typedef struct packed { logic [15:0] addr; logic [15:0] data; } wr_t;

  rd_t         rdq[$];
  fill_t       exp_fill[$];
  logic [15:0] exp_raddr[$];
  wr_t         exp_wr[$];

  int cyc = 0;
  int mem_lat = 4;
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a * 16'd7) ^ 16'hA55A;
  endfunction

  // Memory model: observes issues just after the edge, answers mem_lat cycles later.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_fn(rdq[0].addr);
      void'(rdq.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
    if (mem_enable && !mem_wr) rdq.push_back('{due: cyc + mem_lat, addr: mem_addr});
  end

  // Scoreboard monitor: read addresses, writes and fill words in expected order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (icache_fill_we || dcache_fill_we) begin
        n_vec++;
        if (exp_fill.size() == 0) begin
          n_err++;
          $display("FAIL fill_unexpected: got i_we=%b d_we=%b idx=%0d, expected none", icache_fill_we, dcache_fill_we, fill_idx);
        end else begin
          fill_t e;
          e = exp_fill.pop_front();
          if ({dcache_fill_we, icache_fill_we, fill_idx, fill_data} !== {e.d, ~e.d, e.idx, e.data}) begin
            n_err++;
            $display("FAIL fill_word: got d=%b i=%b idx=%0d data=%h, expected d=%b idx=%0d data=%h",
                     dcache_fill_we, icache_fill_we, fill_idx, fill_data, e.d, e.idx, e.data);
          end
        end
      end
      if (mem_enable && !mem_wr) begin
        n_vec++;
        if (exp_raddr.size() == 0) begin
          n_err++;
          $display("FAIL read_unexpected: got addr=%h, expected no read", mem_addr);
        end else begin
          logic [15:0] ea;
          ea = exp_raddr.pop_front();
          if (mem_addr !== ea) begin
            n_err++;
            $display("FAIL read_addr: got %h, expected %h", mem_addr, ea);
          end
        end
      end
      if (mem_enable && mem_wr) begin
        n_vec++;
        if (exp_wr.size() == 0) begin
          n_err++;
          $display("FAIL write_unexpected: got addr=%h data=%h", mem_addr, mem_wdata);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          if ({mem_addr, mem_wdata} !== {w.addr, w.data}) begin
            n_err++;
            $display("FAIL write_word: got %h/%h, expected %h/%h", mem_addr, mem_wdata, w.addr, w.data);
          end
        end
      end
      if (!mem_enable && {mem_wr, mem_addr, mem_wdata} !== 33'd0) begin
        n_vec++;
        n_err++;
        $display("FAIL idle_bus: got wr=%b addr=%h wdata=%h, expected zeros", mem_wr, mem_addr, mem_wdata);
      end
    end
  end

  task automatic push_fill(input logic d, input logic [15:0] addr);
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  ix;
      logic [15:0] a;
      ix = i[2:0];
      a  = {addr[15:4], ix, 1'b0};
      exp_raddr.push_back(a);
      exp_fill.push_back('{d: d, idx: ix, data: mem_fn(a)});
    end
  endtask

  // One complete block fill with latency checks.
  task automatic do_fill(input logic own_d, input logic [15:0] addr, input int lat, input string nm);
    int t0, first_iss, last_iss, first_we, n_we, done_at, bad_other;
    mem_lat = lat;
    @(negedge clk);
    t0 = cyc;
    push_fill(own_d, addr);
    if (own_d) begin dcache_miss = 1'b1; dcache_miss_addr = addr; end
    else       begin icache_miss = 1'b1; icache_miss_addr = addr; end
    first_iss = -1; last_iss = -1; first_we = -1; n_we = 0; done_at = -1; bad_other = 0;
    for (int k = 0; k < 40 && done_at < 0; k++) begin
      @(negedge clk);
      if (mem_enable && !mem_wr) begin
        if (first_iss < 0) first_iss = cyc;
        last_iss = cyc;
      end
      if (own_d ? dcache_fill_we : icache_fill_we) begin
        if (first_we < 0) first_we = cyc;
        n_we++;
      end
      if (own_d ? (icache_fill_we | icache_fill_done)
                : (dcache_fill_we | dcache_fill_done | dcache_wr_ack)) bad_other++;
      if (own_d ? dcache_fill_done : icache_fill_done) done_at = cyc;
    end
    icache_miss = 1'b0;
    dcache_miss = 1'b0;
    n_vec++;
    if (first_iss !== t0 + 1 || last_iss !== t0 + 8) begin
      n_err++;
      $display("FAIL %s issue_window: got %0d..%0d, expected %0d..%0d", nm, first_iss - t0, last_iss - t0, 1, 8);
    end
    n_vec++;
    if (first_we !== t0 + 1 + lat || n_we !== 8) begin
      n_err++;
      $display("FAIL %s fill_we: got first=%0d count=%0d, expected first=%0d count=8", nm, first_we - t0, n_we, 1 + lat);
    end
    n_vec++;
    if (done_at !== t0 + 9 + lat) begin
      n_err++;
      $display("FAIL %s done_cycle: got %0d, expected %0d", nm, done_at - t0, 9 + lat);
    end
    n_vec++;
    if (bad_other !== 0) begin
      n_err++;
      $display("FAIL %s other_cache: got %0d stray pulses, expected 0", nm, bad_other);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({mem_enable, mem_wr, mem_addr, mem_wdata, icache_fill_we, dcache_fill_we, fill_idx,
         icache_fill_done, dcache_fill_done, dcache_wr_ack, icache_busy, dcache_busy} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got en=%b wr=%b addr=%h wdata=%h idx=%0d ibusy=%b dbusy=%b, expected all 0",
               mem_enable, mem_wr, mem_addr, mem_wdata, fill_idx, icache_busy, dcache_busy);
    end
  endtask

  task automatic test_priority();
    int t0, d_done, i_done, i_first, busy_drop;
    mem_lat = 3;
    @(negedge clk);
    t0 = cyc;
    push_fill(1'b1, 16'h4A52);
    push_fill(1'b0, 16'h1236);
    dcache_miss = 1'b1; dcache_miss_addr = 16'h4A52;
    icache_miss = 1'b1; icache_miss_addr = 16'h1236;
    d_done = -1; i_done = -1; i_first = -1; busy_drop = 0;
    for (int k = 0; k < 80 && i_done < 0; k++) begin
      @(negedge clk);
      if (!icache_busy) busy_drop++;
      if (d_done >= 0 && i_first < 0 && mem_enable && !mem_wr) i_first = cyc;
      if (dcache_fill_done) begin d_done = cyc; dcache_miss = 1'b0; end
      if (icache_fill_done) begin i_done = cyc; icache_miss = 1'b0; end
    end
    icache_miss = 1'b0;
    dcache_miss = 1'b0;
    n_vec++;
    if (d_done !== t0 + 12) begin
      n_err++;
      $display("FAIL prio_d_first: got d_done=%0d, expected %0d", d_done - t0, 12);
    end
    n_vec++;
    if (i_first !== d_done + 2 || i_done !== d_done + 13) begin
      n_err++;
      $display("FAIL prio_i_after: got i_first=%0d i_done=%0d, expected %0d/%0d",
               i_first - t0, i_done - t0, d_done + 2 - t0, d_done + 13 - t0);
    end
    n_vec++;
    if (busy_drop !== 0) begin
      n_err++;
      $display("FAIL prio_ibusy: got %0d cycles low, expected 0", busy_drop);
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    exp_wr.push_back('{addr: 16'h00A4, data: 16'hBEEF});
    dcache_wr = 1'b1; dcache_wr_addr = 16'h00A4; dcache_wr_data = 16'hBEEF;
    @(negedge clk);
    n_vec++;
    if ({mem_enable, mem_wr, mem_addr, mem_wdata, dcache_wr_ack, dcache_busy} !== {1'b1, 1'b1, 16'h00A4, 16'hBEEF, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL write_cycle: got en=%b wr=%b addr=%h data=%h ack=%b, expected 1 1 00a4 beef 1",
               mem_enable, mem_wr, mem_addr, mem_wdata, dcache_wr_ack);
    end
    dcache_wr = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({mem_enable, dcache_wr_ack, dcache_busy} !== 3'b000) begin
      n_err++;
      $display("FAIL write_idle: got en=%b ack=%b busy=%b, expected 0 0 0", mem_enable, dcache_wr_ack, dcache_busy);
    end
  endtask

  task automatic test_wr_during_fill();
    int i_done, ack_at, early_wr;
    mem_lat = 4;
    @(negedge clk);
    push_fill(1'b0, 16'h2468);
    exp_wr.push_back('{addr: 16'h0310, data: 16'h1234});
    icache_miss = 1'b1; icache_miss_addr = 16'h2468;
    i_done = -1; ack_at = -1; early_wr = 0;
    for (int k = 0; k < 60 && ack_at < 0; k++) begin
      @(negedge clk);
      if (k == 2) begin dcache_wr = 1'b1; dcache_wr_addr = 16'h0310; dcache_wr_data = 16'h1234; end
      if (mem_enable && mem_wr && i_done < 0) early_wr++;
      if (icache_fill_done) begin i_done = cyc; icache_miss = 1'b0; end
      if (dcache_wr_ack) begin ack_at = cyc; dcache_wr = 1'b0; end
    end
    icache_miss = 1'b0;
    dcache_wr = 1'b0;
    n_vec++;
    if (early_wr !== 0) begin
      n_err++;
      $display("FAIL wr_preempt: got %0d writes before fill done, expected 0", early_wr);
    end
    n_vec++;
    if (i_done < 0 || ack_at !== i_done + 2) begin
      n_err++;
      $display("FAIL wr_ack_delay: got ack-done=%0d (done=%0d), expected 2", ack_at - i_done, i_done);
    end
    n_vec++;
    if (exp_fill.size() !== 0) begin
      n_err++;
      $display("FAIL wr_fill_words: got %0d words missing, expected 0", exp_fill.size());
    end
  endtask

  task automatic test_reset_midfill();
    int nwe, late_we;
    mem_lat = 4;
    @(negedge clk);
    push_fill(1'b1, 16'h0800);
    dcache_miss = 1'b1; dcache_miss_addr = 16'h0800;
    nwe = 0;
    for (int k = 0; k < 30 && nwe < 3; k++) begin
      @(negedge clk);
      if (dcache_fill_we) nwe++;
    end
    #2;
    rst_n = 1'b0;
    dcache_miss = 1'b0;
    #1;
    exp_fill.delete();
    exp_raddr.delete();
    n_vec++;
    if ({mem_enable, mem_wr, mem_addr, mem_wdata, icache_fill_we, dcache_fill_we, fill_idx,
         icache_fill_done, dcache_fill_done, dcache_wr_ack, dcache_busy} !== '0) begin
      n_err++;
      $display("FAIL rst_async: got en=%b addr=%h d_we=%b idx=%0d busy=%b, expected all 0",
               mem_enable, mem_addr, dcache_fill_we, fill_idx, dcache_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    late_we = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (icache_fill_we || dcache_fill_we) late_we++;
    end
    n_vec++;
    if (late_we !== 0) begin
      n_err++;
      $display("FAIL rst_late_rvalid: got %0d fill writes, expected 0", late_we);
    end
    do_fill(1'b1, 16'h0806, 4, "refill");
  endtask

  initial begin
    test_reset();
    do_fill(1'b0, 16'h1236, 4, "imiss_L4");
    test_priority();
    test_write();
    test_wr_during_fill();
    test_reset_midfill();
    do_fill(1'b0, 16'h1236, 1, "lat_L1");
    do_fill(1'b1, 16'hFFF0, 7, "lat_L7");
    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_fill.size() !== 0 || exp_raddr.size() !== 0 || exp_wr.size() !== 0) begin
      n_err++;
      $display("FAIL drain: got %0d/%0d/%0d left, expected 0/0/0", exp_fill.size(), exp_raddr.size(), exp_wr.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
